mult_seq: RTL and testbench

Iterative 32x32 shift-add multiplier producing a 64-bit product in HI/LO form; serves MULT and MULTU and shares the start/busy handshake of the divider. The CPU core pulses `start` with operands and stalls on `busy`. It samples `hi`/`lo` when `done` pulses, or any time after `busy` falls. One product bit per cycle; 32 iteration cycles per operation.

---
 rtl/mult_seq_if.sv | 21 ++
 rtl/mult_seq.sv | 82 ++++++++
 tb/tb_mult_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// Start/busy handshake bundle shared by the iterative multiplier and its CPU-side master.
interface mult_seq_if;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        is_signed;
   logic        start;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   modport master (
      output multiplicand, multiplier, is_signed, start,
      input  hi, lo, busy, done
   );

   modport slave (
      input  multiplicand, multiplier, is_signed, start,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/mult_seq.sv
// Iterative 32x32 shift-add multiplier (MULT/MULTU), one product bit per cycle,
// result delivered in HI/LO with a one-cycle done pulse.
module mult_seq (
   input  logic        clock,
   input  logic        reset,
   mult_seq_if.slave   bus
);
   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      r_state;
   logic [31:0] r_mcand;
   logic [31:0] r_acc;
   logic [31:0] r_mplr;
   logic        r_neg;
   logic [4:0]  r_count;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;

   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_sum;
   logic [63:0] w_shift;
   logic [63:0] w_result;

   // Two's-complement negate leaves 0x80000000 unchanged, which is its correct magnitude.
   assign w_abs_a = (bus.is_signed && bus.multiplicand[31]) ? (~bus.multiplicand + 32'd1)
                                                             : bus.multiplicand;
   assign w_abs_b = (bus.is_signed && bus.multiplier[31]) ? (~bus.multiplier + 32'd1)
                                                           : bus.multiplier;

   // The adder carry becomes the top bit of the shifted partial product.
   assign w_sum    = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : 33'd0);
   assign w_shift  = {w_sum, r_mplr[31:1]};
   assign w_result = r_neg ? (~w_shift + 64'd1) : w_shift;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_mcand <= 32'd0;
         r_acc   <= 32'd0;
         r_mplr  <= 32'd0;
         r_neg   <= 1'b0;
         r_count <= 5'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_done  <= 1'b0;
      end else if (bus.start) begin
         r_state <= S_RUN;
         r_mcand <= w_abs_a;
         r_mplr  <= w_abs_b;
         r_acc   <= 32'd0;
         r_neg   <= bus.is_signed & (bus.multiplicand[31] ^ bus.multiplier[31]);
         r_count <= 5'd0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_acc   <= w_shift[63:32];
               r_mplr  <= w_shift[31:0];
               r_count <= r_count + 5'd1;
               if (r_count == 5'd31) begin
                  r_hi    <= w_result[63:32];
                  r_lo    <= w_result[31:0];
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
   assign bus.busy = (r_state == S_RUN);
   assign bus.done = r_done;
endmodule

// File: tb/tb_mult_seq.sv
// Directed and random checks of mult_seq against a 64-bit arithmetic product model.
module tb_mult_seq;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_fail;
   logic [63:0] prev;

   mult_seq_if bus ();

   mult_seq dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         return sa * sb;
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.is_signed    = s;
      bus.start        = 1'b1;
      @(negedge clock);
      bus.start        = 1'b0;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      bus.is_signed    = 1'($urandom_range(0, 1));
   endtask

   // Called at a falling edge; returns at a falling edge (the done cycle when chained).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit chain);
      logic [63:0] exp;
      int cyc;
      exp = ref_prod(a, b, s);
      drive_start(a, b, s);
      check("busy_after_start", 64'(bus.busy), 64'd1);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         check("hilo_hold", {bus.hi, bus.lo}, prev);
         @(negedge clock);
         cyc++;
      end
      check("latency", 64'(cyc), 64'd32);
      check("done_pulse", 64'(bus.done), 64'd1);
      check("busy_end", 64'(bus.busy), 64'd0);
      check("product", {bus.hi, bus.lo}, exp);
      $display("op a=%h b=%h signed=%0d -> hi=%h lo=%h (exp %h) cycles=%0d",
               a, b, s, bus.hi, bus.lo, exp, cyc);
      prev = exp;
      if (!chain) begin
         @(negedge clock);
         check("done_fall", 64'(bus.done), 64'd0);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rs;
      n_cmp  = 0;
      n_fail = 0;
      prev   = 64'd0;
      bus.multiplicand = 32'd0;
      bus.multiplier   = 32'd0;
      bus.is_signed    = 1'b0;
      bus.start        = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);

      run_op(32'd3, 32'd5, 1'b0, 1'b0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      check("u_ffff_hi", 64'(bus.hi), 64'hFFFFFFFE);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
      check("s_m1m1_lo", 64'(bus.lo), 64'd1);
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
      run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0);
      check("s_minmin_hi", 64'(bus.hi), 64'h40000000);
      run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
      check("s_min1", {bus.hi, bus.lo}, 64'hFFFFFFFF80000000);

      // Restart: second start at cycle 10 abandons the first operation.
      drive_start(32'd7, 32'd9, 1'b0);
      for (int i = 0; i < 9; i++) begin
         check("restart_no_done", 64'(bus.done), 64'd0);
         @(negedge clock);
      end
      run_op(32'h00010000, 32'h00010000, 1'b0, 1'b0);
      check("restart_val", {bus.hi, bus.lo}, 64'h0000000100000000);

      // Asynchronous reset mid-operation, asserted between clock edges.
      drive_start(32'h12345678, 32'h9ABCDEF0, 1'b0);
      for (int i = 0; i < 14; i++) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
      #1 reset = 1'b0;
      prev = 64'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         check("arst_no_done", 64'(bus.done | bus.busy), 64'd0);
      end
      run_op(32'd2, 32'd2, 1'b0, 1'b0);
      check("after_rst_lo", 64'(bus.lo), 64'd4);

      // Back-to-back: next start lands in the done cycle.
      run_op(32'd6, 32'd7, 1'b0, 1'b1);
      check("b2b_first", 64'(bus.lo), 64'd42);
      run_op(32'd0, 32'hDEADBEEF, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (i % 4 == 1) ra = 32'($urandom_range(0, 255));
         if (i % 4 == 2) rb = -32'($urandom_range(1, 255));
         run_op(ra, rb, rs, (i % 3 == 0));
      end
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
